// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: owns the program counter, fetches one word per instruction
// over a req/ready handshake and holds it for the decoder until it is consumed.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0040_0000,
  parameter int          WAIT_LIMIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Jump,
  input  logic        BranchEQ,
  input  logic        BranchNE,
  input  logic        Zero,
  input  logic [31:0] BranchImm,
  input  logic        Stall,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] Instruction,
  output logic        InstrValid,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        FetchError
);

  localparam int CW = (WAIT_LIMIT > 2) ? $clog2(WAIT_LIMIT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD,
    ERR
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic            valid_q, valid_d;
  logic            req_q, req_d;
  logic            err_q, err_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [31:0]     pcPlus4;
  logic [31:0]     jumpTarget;
  logic [31:0]     branchTarget;
  logic            branchTaken;
  logic [31:0]     nextPc;

  assign pcPlus4      = pc_q + 32'd4;
  assign jumpTarget   = {pcPlus4[31:28], instr_q[25:0], 2'b00};
  assign branchTarget = pcPlus4 + {BranchImm[29:0], 2'b00};
  assign branchTaken  = (BranchEQ & Zero) | (BranchNE & ~Zero);

  // Jump has priority over any branch; everything else falls through to PC+4.
  always_comb begin
    nextPc = pcPlus4;
    if (Jump) begin
      nextPc = jumpTarget;
    end else if (branchTaken) begin
      nextPc = branchTarget;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        state_d = REQ;
      end
      REQ: begin
        if (imem_ready) begin
          instr_d = imem_rdata;
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = HOLD;
        end else if (cnt_q == CW'(WAIT_LIMIT - 1)) begin
          err_d   = 1'b1;
          state_d = ERR;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HOLD: begin
        if (!Stall) begin
          pc_d    = nextPc;
          valid_d = 1'b0;
          state_d = REQ;
        end
      end
      ERR: begin
        valid_d = 1'b0;
        err_d   = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The request is registered, so it is derived from the state being entered.
  assign req_d = (state_d == REQ);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      req_q   <= req_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign Instruction = instr_q;
  assign InstrValid  = valid_q;
  assign PC          = pc_q;
  assign PCPlus4     = pcPlus4;
  assign FetchError  = err_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: sequential fetch, branches, jump, stall,
// memory timeout and asynchronous reset during a request.
module tb_fetch_pc_unit;

  logic        clk;
  logic        reset;
  logic        Jump;
  logic        BranchEQ;
  logic        BranchNE;
  logic        Zero;
  logic [31:0] BranchImm;
  logic        Stall;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] Instruction;
  logic        InstrValid;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        FetchError;

  int compared;
  int mismatched;

  fetch_pc_unit dut (
    .clk        (clk),
    .reset      (reset),
    .Jump       (Jump),
    .BranchEQ   (BranchEQ),
    .BranchNE   (BranchNE),
    .Zero       (Zero),
    .BranchImm  (BranchImm),
    .Stall      (Stall),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .Instruction(Instruction),
    .InstrValid (InstrValid),
    .PC         (PC),
    .PCPlus4    (PCPlus4),
    .FetchError (FetchError)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic nextCycle();
    @(negedge clk);
  endtask

  // Expects the unit in REQ at expAddr, returns one word with ready and checks the capture.
  task automatic applyStimulus(input logic [31:0] expAddr, input logic [31:0] word);
    checkOutput("reqHigh", {31'd0, imem_req}, 32'd1);
    checkOutput("reqAddr", imem_addr, expAddr);
    imem_ready = 1'b1;
    imem_rdata = word;
    nextCycle();
    imem_ready = 1'b0;
    imem_rdata = 32'hBAD0_BAD0;
    checkOutput("valid", {31'd0, InstrValid}, 32'd1);
    checkOutput("instr", Instruction, word);
    checkOutput("reqLowHold", {31'd0, imem_req}, 32'd0);
    checkOutput("heldPc", PC, expAddr);
  endtask

  // Presents decoder inputs for the held instruction and lets it be consumed.
  task automatic advance(input logic j, input logic beq, input logic bne,
                         input logic z, input logic [31:0] imm);
    Jump      = j;
    BranchEQ  = beq;
    BranchNE  = bne;
    Zero      = z;
    BranchImm = imm;
    Stall     = 1'b0;
    nextCycle();
    Jump      = 1'b0;
    BranchEQ  = 1'b0;
    BranchNE  = 1'b0;
    Zero      = 1'b0;
    BranchImm = 32'd0;
  endtask

  task automatic resetPulse();
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    nextCycle();
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b1;
    Jump       = 1'b0;
    BranchEQ   = 1'b0;
    BranchNE   = 1'b0;
    Zero       = 1'b0;
    BranchImm  = 32'd0;
    Stall      = 1'b0;
    imem_ready = 1'b0;
    imem_rdata = 32'd0;

    repeat (2) nextCycle();
    checkOutput("rstPc", PC, 32'h0040_0000);
    checkOutput("rstReq", {31'd0, imem_req}, 32'd0);
    checkOutput("rstValid", {31'd0, InstrValid}, 32'd0);
    checkOutput("rstInstr", Instruction, 32'd0);
    checkOutput("rstErr", {31'd0, FetchError}, 32'd0);
    checkOutput("rstPcPlus4", PCPlus4, 32'h0040_0004);

    // Release reset: one IDLE cycle, then sequential fetches.
    reset = 1'b0;
    checkOutput("idleReq", {31'd0, imem_req}, 32'd0);
    nextCycle();
    applyStimulus(32'h0040_0000, 32'h1111_0000);
    advance(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    applyStimulus(32'h0040_0004, 32'h1111_0004);
    advance(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    applyStimulus(32'h0040_0008, 32'h1111_0008);
    checkOutput("pcPlus4Seq", PCPlus4, 32'h0040_000C);
    advance(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    applyStimulus(32'h0040_000C, 32'h1111_000C);
    advance(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    applyStimulus(32'h0040_0010, 32'h1111_0010);

    // beq taken with a negative offset, then beq not taken from the same PC.
    advance(1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE);
    applyStimulus(32'h0040_000C, 32'h2222_000C);
    advance(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    applyStimulus(32'h0040_0010, 32'h2222_0010);
    advance(1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE);
    applyStimulus(32'h0040_0014, 32'h3333_0014);

    // Stall holds everything; ready and data in HOLD are ignored.
    Stall      = 1'b1;
    imem_ready = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      nextCycle();
      checkOutput("stallInstr", Instruction, 32'h3333_0014);
      checkOutput("stallValid", {31'd0, InstrValid}, 32'd1);
      checkOutput("stallPc", PC, 32'h0040_0014);
      checkOutput("stallReq", {31'd0, imem_req}, 32'd0);
    end
    imem_ready = 1'b0;
    advance(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput("postStallValid", {31'd0, InstrValid}, 32'd0);
    applyStimulus(32'h0040_0018, 32'h0810_0010);

    // Jump to 0x00400040, then reset asynchronously in the middle of that request.
    advance(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput("jumpReq", {31'd0, imem_req}, 32'd1);
    checkOutput("jumpAddr", imem_addr, 32'h0040_0040);
    #2 reset = 1'b1;
    #1;
    checkOutput("asyncReqDrop", {31'd0, imem_req}, 32'd0);
    checkOutput("asyncPc", PC, 32'h0040_0000);
    nextCycle();
    reset = 1'b0;
    nextCycle();
    applyStimulus(32'h0040_0000, 32'h0810_0008);

    // bne taken with a positive offset.
    advance(1'b0, 1'b0, 1'b1, 1'b0, 32'd3);
    applyStimulus(32'h0040_0010, 32'h4444_0010);

    // Same held word at 0x00400000 with Jump and bne both set: jump wins.
    resetPulse();
    applyStimulus(32'h0040_0000, 32'h0810_0008);
    advance(1'b1, 1'b0, 1'b1, 1'b0, 32'd3);
    applyStimulus(32'h0040_0020, 32'h5555_0020);

    // Ready on the last allowed REQ cycle still captures normally.
    resetPulse();
    for (int i = 0; i < 15; i++) begin
      imem_ready = 1'b0;
      nextCycle();
      checkOutput("waitReq", {31'd0, imem_req}, 32'd1);
    end
    applyStimulus(32'h0040_0000, 32'h6666_0000);
    checkOutput("lateReadyErr", {31'd0, FetchError}, 32'd0);

    // Sixteen REQ cycles without ready give a sticky FetchError.
    advance(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput("toAddr", imem_addr, 32'h0040_0004);
    for (int i = 0; i < 15; i++) nextCycle();
    checkOutput("toNotYetErr", {31'd0, FetchError}, 32'd0);
    checkOutput("toNotYetReq", {31'd0, imem_req}, 32'd1);
    nextCycle();
    checkOutput("toErr", {31'd0, FetchError}, 32'd1);
    checkOutput("toReq", {31'd0, imem_req}, 32'd0);
    checkOutput("toValid", {31'd0, InstrValid}, 32'd0);
    imem_ready = 1'b1;
    imem_rdata = 32'h7777_7777;
    repeat (3) nextCycle();
    checkOutput("errSticky", {31'd0, FetchError}, 32'd1);
    checkOutput("errNoReq", {31'd0, imem_req}, 32'd0);
    checkOutput("errNoValid", {31'd0, InstrValid}, 32'd0);
    imem_ready = 1'b0;
    reset = 1'b1;
    #1;
    checkOutput("errCleared", {31'd0, FetchError}, 32'd0);
    nextCycle();
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
